// File: rtl/mac_share_arbiter_pkg.sv
// Shared types and widths for the mac sharing arbiter and its sub-modules.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mac_share_arbiter_pkg;

  // Operand width of A, B and C on the shared mac.
  localparam int MAC_OP_W  = 16;
  // Result width of the shared mac.
  localparam int MAC_RES_W = 32;

  // Occupancy of the single-entry result stage.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage : mac_share_arbiter_pkg

// File: rtl/mac_share_arbiter_rr.sv
// Round-robin request picker: first set req bit at or after ptr, wrapping to 0.
// Latency: purely combinational, zero cycles.
// Backpressure: en=0 forces an empty grant; the pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               gnt_vld_o
);

  int   idx;
  logic found;

  // Walk ptr, ptr+1, ... modulo NUM_REQ and keep the first requester seen.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = ID_W'(idx);
      end
    end
    gnt_vld_o = found;
  end

endmodule : rr_arbiter

// File: rtl/mac_share_arbiter.sv
// Time-shares one combinational mac among NUM_REQ requesters with round-robin grant.
// Latency: operand accepted in cycle t, tagged result valid in cycle t+1; 1 result/cycle.
// Backpressure: while the result stage is FULL and rsp_ready=0 every req_ready is held low.
module mac_share_arbiter
  import mac_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [MAC_OP_W*NUM_REQ-1:0]   req_a,
  input  logic [MAC_OP_W*NUM_REQ-1:0]   req_b,
  input  logic [MAC_OP_W*NUM_REQ-1:0]   req_c,
  output logic [MAC_OP_W-1:0]           mac_a,
  output logic [MAC_OP_W-1:0]           mac_b,
  output logic [MAC_OP_W-1:0]           mac_c,
  input  logic [MAC_RES_W-1:0]          mac_r,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [MAC_RES_W-1:0]          rsp_data,
  output logic [ID_W-1:0]               rsp_id
);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [MAC_RES_W-1:0]   rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]        rsp_id_q, rsp_id_d;

  logic                   can_issue;
  logic [NUM_REQ-1:0]     gnt;
  logic [ID_W-1:0]        gnt_idx;
  logic                   gnt_vld;
  logic                   issue;

  // The stage can take a new result if it is empty or is being drained this cycle.
  assign can_issue = (state_q == EMPTY) | rsp_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .en_i      (can_issue),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // The grant is already qualified by req_valid, so a grant is a transfer.
  assign req_ready = gnt;
  assign issue     = gnt_vld;

  // One-hot AND-OR operand mux; with no grant the mac inputs sit at zero.
  always_comb begin
    mac_a = '0;
    mac_b = '0;
    mac_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        mac_a = req_a[i*MAC_OP_W +: MAC_OP_W];
        mac_b = req_b[i*MAC_OP_W +: MAC_OP_W];
        mac_c = req_c[i*MAC_OP_W +: MAC_OP_W];
      end
    end
  end

  // Result-stage occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy: an issue always fills; otherwise a drain empties and a stall holds.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (issue) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (issue) begin
          state_d = FULL;
        end else if (rsp_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Occupancy decode onto the response handshake.
  always_comb begin
    rsp_valid = 1'b0;
    case (state_q)
      EMPTY:   rsp_valid = 1'b0;
      FULL:    rsp_valid = 1'b1;
      default: rsp_valid = 1'b0;
    endcase
  end

  // Capture the mac result and its owner on a transfer; hold otherwise.
  always_comb begin
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    if (issue) begin
      rsp_data_d = mac_r;
      rsp_id_d   = gnt_idx;
    end
  end

  // Rotate priority to just past the winner; an idle cycle leaves it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      if (gnt_idx == ID_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + ID_W'(1);
      end
    end
  end

  // Result payload, owner tag and priority pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      ptr_q      <= '0;
    end else begin
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      ptr_q      <= ptr_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_id   = rsp_id_q;

endmodule : mac_share_arbiter

// File: tb/tb_mac_share_arbiter.sv
// Directed bench for mac_share_arbiter with an exact mac stub (r = a*b + c).
// Latency: inputs change 1ns after a rising edge, outputs sampled before the next.
// Backpressure: rsp_ready is driven directly by the directed steps.
module tb_mac_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic [16*NUM_REQ-1:0] req_c;
  logic [15:0]          mac_a;
  logic [15:0]          mac_b;
  logic [15:0]          mac_c;
  logic [31:0]          mac_r;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_data;
  logic [ID_W-1:0]      rsp_id;

  int checks = 0;
  int errors = 0;

  mac_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_c     (mac_c),
    .mac_r     (mac_r),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  // Exact mac stub.
  assign mac_r = ({16'h0, mac_a} * {16'h0, mac_b}) + {16'h0, mac_c};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] c);
    req_valid[i]       = v;
    req_a[i*16 +: 16]  = a;
    req_b[i*16 +: 16]  = b;
    req_c[i*16 +: 16]  = c;
  endtask

  // Pointer is 2 when the streaming test starts, so ids rotate from 2.
  int          stream_id [8] = '{2, 3, 0, 1, 2, 3, 0, 1};
  logic [3:0]  stream_rdy [8] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010,
                                  4'b0100, 4'b1000, 4'b0001, 4'b0010};

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    rsp_ready = 1'b0;
    #12;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data",  rsp_data,       32'd0);
    chk("reset_rsp_id",    32'(rsp_id),    32'd0);
    chk("reset_mac_a",     32'(mac_a),     32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_req_ready", 32'(req_ready), 32'd0);

    // Single requester 1: 3*5+7 = 22.
    set_req(1, 1'b1, 16'd3, 16'd5, 16'd7);
    rsp_ready = 1'b1;
    #1;
    chk("single_req_ready", 32'(req_ready), 32'b0010);
    chk("single_mac_a",     32'(mac_a),     32'd3);
    chk("single_mac_c",     32'(mac_c),     32'd7);
    step();
    req_valid = '0;
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_rsp_data",  rsp_data,       32'd22);
    chk("single_rsp_id",    32'(rsp_id),    32'd1);
    #1;
    chk("nogrant_mac_a", 32'(mac_a), 32'd0);
    step();
    chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);

    // All four valid, A=i+1 B=2 C=0, one result per cycle.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 16'(i + 1), 16'd2, 16'd0);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("stream_req_ready", 32'(req_ready), 32'(stream_rdy[k]));
      step();
      chk("stream_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stream_rsp_id",    32'(rsp_id),    32'(stream_id[k]));
      chk("stream_rsp_data",  rsp_data,       32'(2 * (stream_id[k] + 1)));
    end

    // Backpressure: holding id1/data4 for three cycles.
    rsp_ready = 1'b0;
    #1;
    chk("stall_req_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_data",  rsp_data,       32'd4);
      chk("stall_rsp_id",    32'(rsp_id),    32'd1);
      chk("stall_ready_low", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("drain_issue_ready", 32'(req_ready), 32'b0100);
    step();
    chk("drain_issue_valid", 32'(rsp_valid), 32'd1);
    chk("drain_issue_id",    32'(rsp_id),    32'd2);
    chk("drain_issue_data",  rsp_data,       32'd6);
    req_valid = '0;
    step();
    chk("empty_again", 32'(rsp_valid), 32'd0);

    // Wrap/skip: ptr=3, only req1 valid.
    set_req(1, 1'b1, 16'd3, 16'd5, 16'd7);
    #1;
    chk("wrap_req_ready", 32'(req_ready), 32'b0010);
    step();
    chk("wrap_rsp_id",   32'(rsp_id), 32'd1);
    chk("wrap_rsp_data", rsp_data,    32'd22);
    // ptr=2: req0 and req2 valid -> req2 first.
    req_valid = '0;
    set_req(0, 1'b1, 16'd10, 16'd10, 16'd1);
    set_req(2, 1'b1, 16'd7,  16'd6,  16'd5);
    #1;
    chk("skip_req_ready", 32'(req_ready), 32'b0100);
    step();
    chk("skip_rsp_id",   32'(rsp_id), 32'd2);
    chk("skip_rsp_data", rsp_data,    32'd47);
    req_valid[2] = 1'b0;
    #1;
    chk("skip2_req_ready", 32'(req_ready), 32'b0001);
    step();
    chk("skip2_rsp_id",   32'(rsp_id), 32'd0);
    chk("skip2_rsp_data", rsp_data,    32'd101);
    req_valid = '0;

    // Max operands on req3 (ptr=1): FFFF*FFFF+FFFF = FFFF0000.
    set_req(3, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    step();
    req_valid = '0;
    chk("max_rsp_id",   32'(rsp_id), 32'd3);
    chk("max_rsp_data", rsp_data,    32'hFFFF_0000);

    // Move ptr to 2, then stall FULL and reset mid-stall.
    set_req(1, 1'b1, 16'd3, 16'd5, 16'd7);
    step();
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    chk("prerst_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("prerst_rsp_id",    32'(rsp_id),    32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(rsp_valid), 32'd0);
    chk("rst_async_data",  rsp_data,       32'd0);
    set_req(0, 1'b1, 16'd10, 16'd10, 16'd1);
    set_req(2, 1'b1, 16'd7,  16'd6,  16'd5);
    rsp_ready = 1'b1;
    step();
    rst_n = 1'b1;
    #1;
    chk("postrst_req_ready", 32'(req_ready), 32'b0001);
    step();
    chk("postrst_rsp_id",   32'(rsp_id), 32'd0);
    chk("postrst_rsp_data", rsp_data,    32'd101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mac_share_arbiter
